md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit for the E stage of the 5-stage MIPS pipeline.
- Consumes the forwarded rs/rt operands, i.e. the outputs of the E-stage forwarding muxes.
- Owns the HI/LO registers and models multi-cycle mult/div latency with a busy counter.
- Drives busy/start to the hazard unit for stalls, and drives mfhi/mflo read data into the E-stage result path.

Parameters:
- MULT_CYCLES, 5, cycles busy is held after a mult/multu start (≥1)
- DIV_CYCLES, 10, cycles busy is held after a div/divu start (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- md_op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9–15 treated as none
- rs_val  in  32  forwarded rs operand
- rt_val  in  32  forwarded rt operand
- start  out  1  combinational; 1 when md_op ∈ {1,2,3,4} and busy==0
- busy  out  1  registered; 1 while an operation is in flight
- hi_o  out  32  current HI register
- lo_o  out  32  current LO register
- md_out  out  32  combinational; HI if md_op==7, LO if md_op==8, else 0

Behaviour:
- Reset (async, reset_n low):
  - HI, LO, counter, pending-result registers ← 0; busy ← 0.
  - Takes effect immediately; an in-flight op is discarded with no HI/LO commit.
- Start (start==1 on a clock edge):
  - Full result is computed from rs_val/rt_val at that edge and latched into pending_hi/pending_lo.
  - counter ← MULT_CYCLES or DIV_CYCLES; busy ← 1.
- Countdown: while busy, counter decrements each edge.
  - At the edge where counter==1: HI/LO ← pending values, busy ← 0, counter ← 0.
  - Total busy duration is exactly N cycles. HI/LO are visible on hi_o/lo_o the cycle busy falls.
- Pending state is never architecturally visible: hi_o/lo_o show the old values throughout busy.
- mult: signed 32x32→64. HI = product[63:32], LO = product[31:0]. multu: same, unsigned.
- div: signed, quotient truncated toward zero. LO = quotient, HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- divu: unsigned. LO = quotient, HI = remainder.
- Divide by zero (div or divu): busy for the full DIV_CYCLES, then HI/LO are left unchanged (no commit).
- mthi/mtlo with busy==0: HI (resp. LO) ← rs_val at the next edge. No busy.
- mfhi/mflo: pure combinational read of the current HI/LO. Values written by mthi/mtlo appear the cycle after the write edge.
- Ops while busy (any of 1–8):
  - The hazard unit must stall when busy | start and the D/E op is an md op.
  - The unit itself ignores md_op 1–6 while busy: no restart, no HI/LO write.
  - mfhi/mflo while busy still output the current (old) HI/LO on md_out. This is a protocol violation; it is not flagged.
- Simultaneous busy end and a new start in the same cycle:
  - start is gated by the registered busy, so a new op can start only in the cycle after busy falls.
- Invalid md_op 9–15: no effect; md_out = 0.
- No flush input. An in-flight op always completes; E-stage flushes must not issue md ops.

Test Plan:
- Reset: hold reset_n low mid-mult (counter=3) → busy=0, hi_o=lo_o=0 immediately; no later commit.
- Signed mult: md_op=1, rs=0xFFFFFFFD (-3), rt=5 → busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1. HI/LO stay old during busy.
- Unsigned mult: md_op=2, rs=0xFFFFFFFF, rt=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- Signed div:
  - md_op=3, rs=0xFFFFFFF9 (-7), rt=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - rs=0x80000000, rt=0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero and busy-ignore: preload HI=0x11, LO=0x22 via mthi/mtlo, then divu 7/0 → busy 10 cycles, HI/LO still 0x11/0x22. An mtlo issued while busy has no effect; start=0 throughout busy.
- Move/read path: mthi rs=0xDEADBEEF → next cycle, md_op=7 gives md_out=0xDEADBEEF; md_op=8 gives the old LO; md_op=0 gives md_out=0. A mult issued the cycle busy falls is not started; issued one cycle later, it starts.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit.
// Owns the architectural HI/LO pair. It computes the full mult/div result
// when an operation starts, holds that result in a private pending pair,
// and commits it to HI/LO only after a fixed busy interval. This models the
// latency of a real iterative unit without needing one.

module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] md_out
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } md_op_e;

  // The counter must hold the longer of the two latencies.
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  md_op_e        op;
  logic          is_md_start_op;

  logic [CW-1:0] counter;
  logic [31:0]   hi_reg;
  logic [31:0]   lo_reg;
  logic [31:0]   pending_hi;
  logic [31:0]   pending_lo;
  logic          pending_commit;

  logic [63:0]   prod_signed;
  logic [63:0]   prod_unsigned;
  logic          dividend_neg;
  logic          divisor_neg;
  logic          div_by_zero;
  logic [31:0]   dividend_mag;
  logic [31:0]   divisor_mag;
  logic [31:0]   udiv_divisor;
  logic [31:0]   sdiv_q_mag;
  logic [31:0]   sdiv_r_mag;
  logic [31:0]   sdiv_quot;
  logic [31:0]   sdiv_rem;
  logic [31:0]   udiv_quot;
  logic [31:0]   udiv_rem;

  logic [31:0]   result_hi;
  logic [31:0]   result_lo;
  logic          result_commit;
  logic [CW-1:0] result_cycles;

  // Decode md_op; codes 9-15 collapse to "none" so they have no effect.
  always_comb begin
    op = OP_NONE;
    if (md_op <= 4'd8) begin
      op = md_op_e'(md_op);
    end
  end

  assign is_md_start_op = (op == OP_MULT) || (op == OP_MULTU) ||
                          (op == OP_DIV)  || (op == OP_DIVU);

  // Start is gated by the registered busy so a new op can never overlap
  // the final cycle of the previous one.
  assign start = is_md_start_op && !busy;

  // Products: sign-extending to 64 bits makes the low 64 bits of an
  // unsigned multiply equal the signed product.
  always_comb begin
    prod_signed   = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    prod_unsigned = {32'd0, rs_val} * {32'd0, rt_val};
  end

  // Division on magnitudes, then fix signs: quotient negative when signs
  // differ, remainder takes the dividend's sign. 0x80000000 / -1 falls out
  // naturally because its magnitude and its negation are both 0x80000000.
  // A zero divisor is replaced by 1 only to keep the datapath defined; that
  // result is never committed.
  always_comb begin
    div_by_zero  = (rt_val == 32'd0);
    dividend_neg = rs_val[31];
    divisor_neg  = rt_val[31];
    dividend_mag = dividend_neg ? (~rs_val + 32'd1) : rs_val;
    divisor_mag  = divisor_neg  ? (~rt_val + 32'd1) : rt_val;
    if (div_by_zero) begin
      divisor_mag = 32'd1;
    end
    udiv_divisor = div_by_zero ? 32'd1 : rt_val;

    sdiv_q_mag = dividend_mag / divisor_mag;
    sdiv_r_mag = dividend_mag % divisor_mag;
    sdiv_quot  = (dividend_neg ^ divisor_neg) ? (~sdiv_q_mag + 32'd1) : sdiv_q_mag;
    sdiv_rem   = dividend_neg ? (~sdiv_r_mag + 32'd1) : sdiv_r_mag;

    udiv_quot  = rs_val / udiv_divisor;
    udiv_rem   = rs_val % udiv_divisor;
  end

  // Select the result, latency and commit decision for the starting op.
  always_comb begin
    result_hi     = 32'd0;
    result_lo     = 32'd0;
    result_commit = 1'b0;
    result_cycles = CW'(MULT_CYCLES);
    case (op)
      OP_MULT: begin
        result_hi     = prod_signed[63:32];
        result_lo     = prod_signed[31:0];
        result_commit = 1'b1;
        result_cycles = CW'(MULT_CYCLES);
      end
      OP_MULTU: begin
        result_hi     = prod_unsigned[63:32];
        result_lo     = prod_unsigned[31:0];
        result_commit = 1'b1;
        result_cycles = CW'(MULT_CYCLES);
      end
      OP_DIV: begin
        result_hi     = sdiv_rem;
        result_lo     = sdiv_quot;
        result_commit = !div_by_zero;
        result_cycles = CW'(DIV_CYCLES);
      end
      OP_DIVU: begin
        result_hi     = udiv_rem;
        result_lo     = udiv_quot;
        result_commit = !div_by_zero;
        result_cycles = CW'(DIV_CYCLES);
      end
      default: begin
        result_hi     = 32'd0;
        result_lo     = 32'd0;
        result_commit = 1'b0;
        result_cycles = CW'(MULT_CYCLES);
      end
    endcase
  end

  // HI/LO, pending result and busy countdown. While busy, all md ops other
  // than the reads are ignored; the commit happens on the edge where the
  // counter reaches its last cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_reg         <= 32'd0;
      lo_reg         <= 32'd0;
      pending_hi     <= 32'd0;
      pending_lo     <= 32'd0;
      pending_commit <= 1'b0;
      counter        <= '0;
      busy           <= 1'b0;
    end else if (busy) begin
      if (counter == CW'(1)) begin
        busy    <= 1'b0;
        counter <= '0;
        if (pending_commit) begin
          hi_reg <= pending_hi;
          lo_reg <= pending_lo;
        end
      end else begin
        counter <= counter - CW'(1);
      end
    end else if (start) begin
      pending_hi     <= result_hi;
      pending_lo     <= result_lo;
      pending_commit <= result_commit;
      counter        <= result_cycles;
      busy           <= 1'b1;
    end else if (op == OP_MTHI) begin
      hi_reg <= rs_val;
    end else if (op == OP_MTLO) begin
      lo_reg <= rs_val;
    end
  end

  assign hi_o = hi_reg;
  assign lo_o = lo_reg;

  // Read path into the E-stage result mux; reads during busy still return
  // the old architectural values.
  always_comb begin
    md_out = 32'd0;
    case (op)
      OP_MFHI: md_out = hi_reg;
      OP_MFLO: md_out = lo_reg;
      default: md_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed bench for md_unit. Each started mult/div pushes its
// expected HI/LO and busy length into a scoreboard queue; a monitor pops and
// compares whenever busy falls. Combinational outputs are checked inline.

module tb_md_unit;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        start;
  logic        busy;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [31:0] md_out;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   mon_busy_cnt = 0;
  logic mon_prev_busy = 1'b0;

  always #5 clk = ~clk;

  md_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .start  (start),
    .busy   (busy),
    .hi_o   (hi_o),
    .lo_o   (lo_o),
    .md_out (md_out)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive new inputs just after a rising edge, then wait for the falling edge
  // where the caller samples outputs.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    md_op  = op;
    rs_val = a;
    rt_val = b;
    @(negedge clk);
  endtask

  task automatic expectCommit(input logic [31:0] hi, input logic [31:0] lo, input int cycles, input string name);
    exp_t e;
    e.hi     = hi;
    e.lo     = lo;
    e.cycles = cycles;
    e.name   = name;
    sb_q.push_back(e);
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    applyStimulus(OP_NONE, 32'd0, 32'd0);
    while (busy !== 1'b0 && n < 30) begin
      applyStimulus(OP_NONE, 32'd0, 32'd0);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_timeout: busy=%b, expected 0 within 30 cycles", name, busy);
    end
  endtask

  // Scoreboard monitor: counts busy cycles and checks HI/LO on each busy fall.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        mon_busy_cnt  = 0;
        mon_prev_busy = 1'b0;
      end else begin
        if (busy === 1'b1) begin
          mon_busy_cnt++;
        end else if (mon_prev_busy === 1'b1) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_commit: got busy fall, expected none (hi=0x%08h lo=0x%08h)", hi_o, lo_o);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            checkOutput({e.name, "_hi"}, hi_o, e.hi);
            checkOutput({e.name, "_lo"}, lo_o, e.lo);
            checkOutput({e.name, "_busy_cycles"}, 32'(mon_busy_cnt), 32'(e.cycles));
          end
          mon_busy_cnt = 0;
        end
        mon_prev_busy = busy;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n = 1'b0;
    md_op   = OP_NONE;
    rs_val  = 32'd0;
    rt_val  = 32'd0;

    // Reset state
    @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_hi", hi_o, 32'd0);
    checkOutput("reset_lo", lo_o, 32'd0);
    checkOutput("reset_start", 32'(start), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Async reset in the middle of a mult discards it
    applyStimulus(OP_MTHI, 32'h55, 32'd0);
    applyStimulus(OP_MTLO, 32'h66, 32'd0);
    applyStimulus(OP_NONE, 32'd0, 32'd0);
    checkOutput("preload_hi", hi_o, 32'h55);
    checkOutput("preload_lo", lo_o, 32'h66);
    applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    checkOutput("rst_mult_start", 32'(start), 32'd1);
    applyStimulus(OP_NONE, 32'd0, 32'd0);
    applyStimulus(OP_NONE, 32'd0, 32'd0);
    checkOutput("rst_mult_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("midop_reset_busy", 32'(busy), 32'd0);
    checkOutput("midop_reset_hi", hi_o, 32'd0);
    checkOutput("midop_reset_lo", lo_o, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(OP_NONE, 32'd0, 32'd0);
    end
    checkOutput("post_reset_busy", 32'(busy), 32'd0);
    checkOutput("post_reset_hi", hi_o, 32'd0);
    checkOutput("post_reset_lo", lo_o, 32'd0);

    // Signed mult; old HI/LO stay visible while busy
    applyStimulus(OP_MTHI, 32'hA, 32'd0);
    applyStimulus(OP_MTLO, 32'hB, 32'd0);
    applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    checkOutput("mult_start", 32'(start), 32'd1);
    expectCommit(32'hFFFF_FFFF, 32'hFFFF_FFF1, 5, "mult");
    applyStimulus(OP_MFHI, 32'd0, 32'd0);
    checkOutput("mult_busy", 32'(busy), 32'd1);
    checkOutput("mult_old_mfhi", md_out, 32'hA);
    checkOutput("mult_old_lo", lo_o, 32'hB);
    checkOutput("mult_busy_start", 32'(start), 32'd0);
    waitIdle("mult");

    // Unsigned mult
    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    expectCommit(32'h0000_0001, 32'hFFFF_FFFE, 5, "multu");
    waitIdle("multu");

    // Signed div, including the overflow corner
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    expectCommit(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div_neg");
    waitIdle("div_neg");
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    expectCommit(32'h0000_0000, 32'h8000_0000, 10, "div_ovf");
    waitIdle("div_ovf");

    // Unsigned div
    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    expectCommit(32'd2, 32'd14, 10, "divu");
    waitIdle("divu");

    // Divide by zero leaves HI/LO alone; ops while busy are ignored
    applyStimulus(OP_MTHI, 32'h11, 32'd0);
    applyStimulus(OP_MTLO, 32'h22, 32'd0);
    applyStimulus(OP_DIVU, 32'd7, 32'd0);
    expectCommit(32'h11, 32'h22, 10, "divu_zero");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_MTLO, 32'h99, 32'd0);
      checkOutput("dz_mtlo_start", 32'(start), 32'd0);
      applyStimulus(OP_MULT, 32'd2, 32'd2);
      checkOutput("dz_mult_start", 32'(start), 32'd0);
      applyStimulus(OP_MFLO, 32'd0, 32'd0);
      checkOutput("dz_mflo_busy", md_out, 32'h22);
    end
    waitIdle("divu_zero");

    // Move/read path
    applyStimulus(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    checkOutput("mthi_md_out", md_out, 32'd0);
    applyStimulus(OP_MFHI, 32'd0, 32'd0);
    checkOutput("mfhi", md_out, 32'hDEAD_BEEF);
    applyStimulus(OP_MFLO, 32'd0, 32'd0);
    checkOutput("mflo", md_out, 32'h22);
    applyStimulus(OP_NONE, 32'd0, 32'd0);
    checkOutput("none_md_out", md_out, 32'd0);
    applyStimulus(4'd9, 32'h1234, 32'd1);
    checkOutput("op9_md_out", md_out, 32'd0);
    checkOutput("op9_start", 32'(start), 32'd0);
    applyStimulus(4'd15, 32'h5678, 32'd1);
    checkOutput("op15_md_out", md_out, 32'd0);
    checkOutput("op15_hi", hi_o, 32'hDEAD_BEEF);
    checkOutput("op15_lo", lo_o, 32'h22);

    // A mult during the last busy cycle is not started; one cycle later it is
    applyStimulus(OP_MULT, 32'd2, 32'd3);
    expectCommit(32'd0, 32'd6, 5, "mult_a");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(OP_NONE, 32'd0, 32'd0);
    end
    applyStimulus(OP_MULT, 32'd7, 32'd8);
    checkOutput("last_cycle_busy", 32'(busy), 32'd1);
    checkOutput("last_cycle_start", 32'(start), 32'd0);
    applyStimulus(OP_MULT, 32'd7, 32'd8);
    checkOutput("after_fall_busy", 32'(busy), 32'd0);
    checkOutput("after_fall_start", 32'(start), 32'd1);
    expectCommit(32'd0, 32'd56, 5, "mult_b");
    waitIdle("mult_b");

    applyStimulus(OP_NONE, 32'd0, 32'd0);
    applyStimulus(OP_NONE, 32'd0, 32'd0);
    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
